timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_pkg.sv | 21 ++
 rtl/timer_chan.sv | 73 +++++++
 rtl/timer_bank.sv | 67 ++++++
 tb/tb_timer_bank.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: channel FSM encoding, register
// offsets within a channel, and CTRL bit positions.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_FIRE  = 2'd3
  } chan_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_MASK = 2;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: CTRL/PRESET/COUNT/pending registers and the sequencing FSM.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | stopped, waiting for CTRL.enable
//   ST_LOAD  | copy PRESET into COUNT
//   ST_COUNT | decrement once per cycle; at zero raise pending, go FIRE
//   ST_FIRE  | one-shot: drop enable, stop; auto-reload: reload and count
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  logic             wr_preset,
  input  logic             wr_status,
  input  logic [31:0]      wdata,
  output logic [2:0]       ctrl,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pending
);

  chan_state_e state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl)   ctrl   <= wdata[2:0];
      if (wr_preset) preset <= wdata[CNT_W-1:0];
      // a clear issued on the fire edge is overridden below, so the event is not lost
      if (wr_status && wdata[0]) pending <= 1'b0;

      if (!ctrl[CTRL_EN]) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_LOAD;
          ST_LOAD: begin
            count <= preset;
            state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (count == '0) begin
              pending <= 1'b1;
              state   <= ST_FIRE;
            end else begin
              count <= count - 1'b1;
            end
          end
          ST_FIRE: begin
            if (ctrl[CTRL_MODE]) begin
              count <= preset;
              state <= ST_COUNT;
            end else begin
              ctrl[CTRL_EN] <= 1'b0;
              state         <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent down-counting timers behind a small word-addressed
// register file; holds address decode, read mux and interrupt reduction.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic            IRQ,
  output logic [N_CH-1:0] irq_vec
);

  logic [2:0] addr_ch;
  logic [1:0] addr_reg;

  assign addr_ch  = Addr[4:2];
  assign addr_reg = Addr[1:0];

  logic [2:0]       ctrl_q   [N_CH];
  logic [CNT_W-1:0] preset_q [N_CH];
  logic [CNT_W-1:0] count_q  [N_CH];
  logic [N_CH-1:0]  pending;

  // channels beyond N_CH simply have no instance to hit, so their writes vanish
  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    logic hit;
    assign hit = WE && (addr_ch == 3'(g));

    timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (hit && (addr_reg == REG_CTRL)),
      .wr_preset (hit && (addr_reg == REG_PRESET)),
      .wr_status (hit && (addr_reg == REG_STATUS)),
      .wdata     (Din),
      .ctrl      (ctrl_q[g]),
      .preset    (preset_q[g]),
      .count     (count_q[g]),
      .pending   (pending[g])
    );

    assign irq_vec[g] = pending[g] & ctrl_q[g][CTRL_MASK];
  end

  assign IRQ = |irq_vec;

  always_comb begin
    Dout = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (addr_ch == 3'(i)) begin
        case (addr_reg)
          REG_CTRL:   Dout = {29'b0, ctrl_q[i]};
          REG_PRESET: Dout = 32'(preset_q[i]);
          REG_COUNT:  Dout = 32'(count_q[i]);
          default:    Dout = {31'b0, pending[i]};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: expected values are queued as stimulus
// is issued and popped when the corresponding DUT output is sampled.
module tb_timer_bank;

  localparam int N_CH  = 2;
  localparam int CNT_W = 32;

  logic            clk;
  logic            reset;
  logic [4:0]      Addr;
  logic            WE;
  logic [31:0]     Din;
  logic [31:0]     Dout;
  logic            IRQ;
  logic [N_CH-1:0] irq_vec;

  timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .IRQ     (IRQ),
    .irq_vec (irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] ad(input int ch, input logic [1:0] r);
    return {3'(ch), r};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    sb.push_back('{"rst_ctrl0", 32'd0});
    sb.push_back('{"rst_preset1", 32'd0});
    sb.push_back('{"rst_irq", 32'd0});
    #3;
    rd(ad(0, 2'd0), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    rd(ad(1, 2'd1), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    e = sb.pop_front(); checks++;
    if ({29'b0, IRQ, irq_vec} !== e.exp) begin
      errors++; $display("FAIL %s got %b/%b want 0", e.name, IRQ, irq_vec);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick(1);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int t;
    wr(ad(0, 2'd1), 32'd3);
    sb.push_back('{"os_pend_t5", 32'd0});
    sb.push_back('{"os_pend_t6", 32'd1});
    sb.push_back('{"os_irq_t6", 32'd1});
    sb.push_back('{"os_ctrl_after", 32'd4});
    wr(ad(0, 2'd0), 32'b101);
    t = cyc;
    tick(5);
    rd(ad(0, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp || IRQ !== 1'b0) begin
      errors++; $display("FAIL %s got %h irq %b want %h at cycle %0d", e.name, d, IRQ, e.exp, cyc - t);
    end
    tick(1);
    rd(ad(0, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    e = sb.pop_front(); checks++;
    if ({31'b0, IRQ} !== e.exp) begin errors++; $display("FAIL %s got %b want %h", e.name, IRQ, e.exp); end
    tick(1);
    rd(ad(0, 2'd0), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    wr(ad(0, 2'd3), 32'd1);
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int t;
    wr(ad(1, 2'd1), 32'd2);
    wr(ad(1, 2'd0), 32'b111);
    t = cyc;
    sb.push_back('{"ar_fire1", 32'd5});
    sb.push_back('{"ar_fire2", 32'd9});
    sb.push_back('{"ar_fire3", 32'd13});
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      if (irq_vec[1]) begin
        e = sb.pop_front(); checks++;
        if (32'(cyc - t) !== e.exp) begin
          errors++; $display("FAIL %s got cycle %0d want %0d", e.name, cyc - t, e.exp);
        end
        Addr = ad(1, 2'd3);
        Din  = 32'd1;
        WE   = 1'b1;
      end else begin
        WE = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    WE = 1'b0;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL ar_timeout got %0d fires missing want 0", sb.size());
      sb.delete();
    end
    wr(ad(1, 2'd0), 32'd0);
    tick(3);
    wr(ad(1, 2'd3), 32'd1);
    sb.push_back('{"ar_stopped", 32'd0});
    tick(6);
    rd(ad(1, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
  endtask

  task automatic test_preset_zero();
    logic [31:0] d;
    wr(ad(0, 2'd1), 32'd0);
    sb.push_back('{"pz_pend_t2", 32'd0});
    sb.push_back('{"pz_pend_t3", 32'd1});
    sb.push_back('{"pz_count_t3", 32'd0});
    sb.push_back('{"pz_count_t4", 32'd0});
    wr(ad(0, 2'd0), 32'd1);
    tick(2);
    rd(ad(0, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    tick(1);
    rd(ad(0, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    rd(ad(0, 2'd2), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    tick(1);
    rd(ad(0, 2'd2), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    wr(ad(0, 2'd3), 32'd1);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    wr(ad(0, 2'd1), 32'd1);
    sb.push_back('{"col_set_wins", 32'd1});
    sb.push_back('{"col_w1c_clears", 32'd0});
    wr(ad(0, 2'd0), 32'b101);
    tick(3);
    wr(ad(0, 2'd3), 32'd1);
    rd(ad(0, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    wr(ad(0, 2'd3), 32'd1);
    rd(ad(0, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp || IRQ !== 1'b0) begin
      errors++; $display("FAIL %s got %h irq %b want %h", e.name, d, IRQ, e.exp);
    end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    wr(ad(1, 2'd1), 32'd1);
    sb.push_back('{"mask_pend", 32'd1});
    sb.push_back('{"mask_irq_off", 32'd0});
    sb.push_back('{"mask_irq_on", 32'b110});
    wr(ad(1, 2'd0), 32'd1);
    tick(4);
    rd(ad(1, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    e = sb.pop_front(); checks++;
    if ({29'b0, IRQ, irq_vec} !== e.exp) begin
      errors++; $display("FAIL %s got %b/%b want 0", e.name, IRQ, irq_vec);
    end
    wr(ad(1, 2'd0), 32'b100);
    e = sb.pop_front(); checks++;
    if ({29'b0, IRQ, irq_vec} !== e.exp) begin
      errors++; $display("FAIL %s got %b/%b want %b", e.name, IRQ, irq_vec, e.exp[2:0]);
    end
    wr(ad(1, 2'd3), 32'd1);
    wr(ad(1, 2'd0), 32'd0);
  endtask

  task automatic test_decode();
    logic [31:0] d;
    sb.push_back('{"dec_preset1", 32'h0000_1234});
    sb.push_back('{"dec_preset0", 32'hFFFF_FFFF});
    sb.push_back('{"dec_count_ro", 32'd0});
    sb.push_back('{"dec_oor_read", 32'd0});
    sb.push_back('{"dec_ctrl_hi", 32'd0});
    wr(ad(1, 2'd1), 32'h0000_1234);
    wr(ad(0, 2'd1), 32'hFFFF_FFFF);
    rd(ad(1, 2'd1), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    rd(ad(0, 2'd1), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    wr(ad(0, 2'd2), 32'h55);
    rd(ad(0, 2'd2), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    wr(ad(2, 2'd1), 32'hAB);
    rd(ad(2, 2'd1), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    wr(ad(0, 2'd0), 32'hFFFF_FFF8);
    rd(ad(0, 2'd0), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    wr(ad(0, 2'd1), 32'd20);
    wr(ad(0, 2'd0), 32'b101);
    sb.push_back('{"mid_count5", 32'd5});
    sb.push_back('{"mid_rst_count", 32'd0});
    sb.push_back('{"mid_rst_ctrl", 32'd0});
    sb.push_back('{"mid_rst_preset", 32'd0});
    sb.push_back('{"mid_rst_irq", 32'd0});
    sb.push_back('{"mid_after_pend", 32'd0});
    sb.push_back('{"mid_after_ctrl", 32'd0});
    tick(17);
    rd(ad(0, 2'd2), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    #1 reset = 1'b0;
    rd(ad(0, 2'd2), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    rd(ad(0, 2'd0), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    rd(ad(0, 2'd1), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    e = sb.pop_front(); checks++;
    if ({29'b0, IRQ, irq_vec} !== e.exp) begin
      errors++; $display("FAIL %s got %b/%b want 0", e.name, IRQ, irq_vec);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick(30);
    rd(ad(0, 2'd3), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
    rd(ad(0, 2'd0), d);
    e = sb.pop_front(); checks++;
    if (d !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, d, e.exp); end
  endtask

  initial begin
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_preset_zero();
    test_w1c_collision();
    test_mask();
    test_decode();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
